// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Accepts a WIDTH-bit word through a valid/ready handshake and emits it
// LSB first on d, one bit per clock with en=1, followed by a one-cycle done
// pulse in IDLE. Every output is decoded from registered state only, so no
// input reaches an output combinationally.
//
// Optional feature: define BIT_SERIALIZER_PARITY_EN to append one even-parity
// bit (XOR of the captured word) after the MSB. done then follows that cycle.
//
// Handshake: a word transfers on a rising edge where load_valid=1 and
// load_ready=1. The source holds load_data/load_valid until that edge.
// load_valid is ignored while load_ready=0.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   reset       in   asynchronous, active-low reset
//   load_data   in   [WIDTH-1:0] word to transmit
//   load_valid  in   load_data is valid
//   load_ready  out  block can accept a word
//   d           out  serial data bit
//   en          out  d carries a valid bit this cycle
//   busy        out  a word is being shifted out
//   done        out  one-cycle pulse after the last bit of a word
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d,
  output logic             en,
  output logic             busy,
  output logic             done
);

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int            CW   = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  state_t           next_state;
  logic [NBITS-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             ready_q;
  logic             take;
  logic             last_bit;
  logic [NBITS-1:0] capture;

  // ready_q is only ever 1 while in IDLE, so this alone qualifies a transfer.
  assign take     = load_valid & ready_q;
  assign last_bit = (state == SHIFT) && (cnt == LAST);

`ifdef BIT_SERIALIZER_PARITY_EN
  assign capture = {^load_data, load_data};
`else
  assign capture = load_data;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take)     next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: shift register, bit counter and the registered handshake/done.
  // ready_q tracks the state we are about to enter, which makes it 0 through
  // reset, 1 from the first edge after release, and 1 in the done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (next_state == IDLE);
      done_q  <= last_bit;
      if (state == IDLE) begin
        if (take) begin
          shreg <= capture;
          cnt   <= '0;
        end
      end else begin
        shreg <= shreg >> 1;
        cnt   <= cnt + CW'(1);
      end
    end
  end

  // Output decode from registers only
  always_comb begin
    load_ready = ready_q;
    busy       = (state == SHIFT);
    en         = (state == SHIFT);
    d          = (state == SHIFT) & shreg[0];
    done       = done_q;
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             d;
  logic             en;
  logic             busy;
  logic             done;

  int n_checks;
  int n_fail;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .d          (d),
    .en         (en),
    .busy       (busy),
    .done       (done)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the cycle of the first bit. Checks every serial bit, stepping
  // after each, and ends in the done cycle after checking it.
  task automatic check_word(input logic [WIDTH-1:0] w, input logic par);
    for (int i = 0; i < WIDTH; i++) begin
      check("bit_en", {31'd0, en}, 32'd1);
      check("bit_busy", {31'd0, busy}, 32'd1);
      check("bit_ready", {31'd0, load_ready}, 32'd0);
      check("bit_d", {31'd0, d}, {31'd0, w[i]});
      step();
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    check("par_en", {31'd0, en}, 32'd1);
    check("par_d", {31'd0, d}, {31'd0, par});
    check("par_done", {31'd0, done}, 32'd0);
    step();
`else
    check("par_unused", {31'd0, par}, {31'd0, par ^ 1'b0});
`endif
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_en", {31'd0, en}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_ready", {31'd0, load_ready}, 32'd1);
    check("done_d", {31'd0, d}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    #1 reset = 1'b0;

    // Reset hold
    repeat (3) step();
    check("rst_d", {31'd0, d}, 32'd0);
    check("rst_en", {31'd0, en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, load_ready}, 32'd0);

    // Release away from the edge; ready rises only at the first edge after.
    // A valid word offered at that edge must not be taken.
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    #2;
    check("rel_ready_pre", {31'd0, load_ready}, 32'd0);
    step();
    check("rel_ready_post", {31'd0, load_ready}, 32'd1);
    check("rel_no_accept", {31'd0, en}, 32'd0);
    load_valid = 1'b0;

    // Idle hold for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_en", {31'd0, en}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
    end
    check("idle_ready", {31'd0, load_ready}, 32'd1);

    // Single word 8'hA5: 1,0,1,0,0,1,0,1, parity 0
    load_data  = 8'hA5;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    load_data  = 8'h00;  // must not disturb the word in flight
    check_word(8'hA5, 1'b0);
    step();
    check("after_done", {31'd0, done}, 32'd0);
    check("after_en", {31'd0, en}, 32'd0);

    // Word 8'h07: parity bit 1
    load_data  = 8'h07;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check_word(8'h07, 1'b1);
    step();

    // Back-to-back: 8'hA5 then 8'h3C offered while shifting
    load_data  = 8'hA5;
    load_valid = 1'b1;
    step();
    load_data  = 8'h3C;  // held valid during shifting, ignored until done
    check_word(8'hA5, 1'b0);
    step();              // 8'h3C taken on the done-cycle edge
    load_valid = 1'b0;
    load_data  = 8'hC3;
    check_word(8'h3C, 1'b0);
    step();
    check("b2b_idle_en", {31'd0, en}, 32'd0);

    // Reset mid-word: 8'hFF, reset after the 3rd bit
    load_data  = 8'hFF;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_d", {31'd0, d}, 32'd1);
      step();
    end
    check("mid_en_pre", {31'd0, en}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_en", {31'd0, en}, 32'd0);
    check("mid_dz", {31'd0, d}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_ready", {31'd0, load_ready}, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_en", {31'd0, en}, 32'd0);
      check("post_rst_done", {31'd0, done}, 32'd0);
    end

    // Next word 8'h01: 1,0,0,0,0,0,0,0, parity 1
    load_data  = 8'h01;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check_word(8'h01, 1'b1);
    step();
    check("final_idle_en", {31'd0, en}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port load_data, input, WIDTH bits: word to transmit.
REQ-005 The block SHALL have port load_valid, input, 1 bit: load_data is valid.
REQ-006 The block SHALL have port load_ready, output, 1 bit: block can accept a word.
REQ-007 The block SHALL have port d, output, 1 bit: serial data bit.
REQ-008 The block SHALL have port en, output, 1 bit: qualifies d; 1 = d carries a valid bit this cycle.
REQ-009 The block SHALL have port busy, output, 1 bit: a word is being shifted out.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a word.

Function
REQ-011 The block SHALL drive all outputs from registers; no combinational path from any input to any output.
REQ-012 The block SHALL implement states IDLE and SHIFT.
REQ-013 In IDLE the block SHALL drive load_ready=1, busy=0, en=0, d=0.
REQ-014 A transfer SHALL occur on a rising edge where load_valid=1 and load_ready=1; load_data is captured and state moves to SHIFT.
REQ-015 In SHIFT the block SHALL drive load_ready=0, busy=1, en=1, with d = current bit, LSB first.
REQ-016 The first bit SHALL appear on d in the cycle immediately after the accepting edge.
REQ-017 Bits SHALL be emitted on consecutive cycles with no gaps: WIDTH cycles, or WIDTH+1 with parity (REQ-025).
REQ-018 After the final bit the block SHALL return to IDLE and assert done=1 for exactly that one IDLE cycle.
REQ-019 During the done cycle load_ready SHALL be 1, so a pending word is accepted back-to-back.
  - Consequence: exactly one en=0 cycle between consecutive words.
REQ-020 The block SHALL ignore load_valid while load_ready=0; the source holds data until accepted.
REQ-021 Changes on load_data after the accepting edge SHALL NOT affect the word being transmitted.
REQ-022 With load_valid=0 the block SHALL remain in IDLE indefinitely, keeping en=0.

Reset
REQ-023 While reset=0 the block SHALL immediately (asynchronously) force state IDLE, clear the shift register and bit counter, and drive d=0, en=0, busy=0, done=0, load_ready=0.
REQ-024 On the first rising edge with reset=1, load_ready SHALL become 1.
  - No transfer is accepted on that edge.
  - A word in progress when reset asserts is discarded; no remaining bits are emitted after release.

Configuration
REQ-025 When macro BIT_SERIALIZER_PARITY_EN is defined, the block SHALL append one even-parity bit (XOR of all WIDTH captured bits) after the MSB, with en=1.
  - done follows the parity cycle.
REQ-026 When BIT_SERIALIZER_PARITY_EN is not defined, no parity bit or parity logic SHALL exist, and done follows the MSB cycle.

Verification (WIDTH=8)
REQ-027 Reset test: hold reset=0 -> d=0, en=0, busy=0, done=0, load_ready=0; release -> load_ready=1 after first edge.
REQ-028 Single word: load 8'hA5 -> d = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with en=1 and busy=1, then one cycle with done=1 and en=0.
REQ-029 Parity test (macro defined):
  - 8'h07 -> 9th bit 1.
  - 8'hA5 -> 9th bit 0.
  - Without macro: no 9th bit, done immediately after the 8th bit.
REQ-030 Back-to-back: hold load_valid=1 with 8'hA5, then 8'h3C presented during shifting -> 8'h3C accepted on the done cycle; its bits 0,0,1,1,1,1,0,0 start after exactly one en=0 cycle.
REQ-031 Reset mid-word: load 8'hFF, assert reset after the 3rd bit -> en, d, busy drop to 0 without waiting for clk; after release, no residual bits; next load 8'h01 sends 1,0,0,0,0,0,0,0.
REQ-032 Idle hold: load_valid=0 for 20 cycles after reset -> en=0 and done=0 throughout.
